// File: rtl/eight_bit_arith_pkg.sv
// Shared types and sizing constants for the sequential arithmetic blocks.
// The divider FSM states and the default operand width live here.
package eight_bit_arith_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/eight_bit_subtractor.sv
// Combinational W-bit A - B, built as A + ~B + 1 over a ripple carry chain.
// The borrow output is the inverted carry out of the top bit.
module eight_bit_subtractor #(
  parameter int W = 9
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_diff,
  output logic         o_borrow
);

  logic w_carry;
  logic w_bInv;

  always_comb begin
    w_carry  = 1'b1;
    w_bInv   = 1'b0;
    o_diff   = '0;
    for (int i = 0; i < W; i++) begin
      w_bInv    = ~i_b[i];
      o_diff[i] = i_a[i] ^ w_bInv ^ w_carry;
      w_carry   = (i_a[i] & w_bInv) | (w_carry & (i_a[i] ^ w_bInv));
    end
    o_borrow = ~w_carry;
  end

endmodule

// File: rtl/eight_bit_divider.sv
// Iterative unsigned restoring divider: one trial subtraction per clock,
// quotient and remainder published on the done edge.
module eight_bit_divider
  import eight_bit_arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] D,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       r_state;
  div_state_t       w_nextState;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_divisor;
  logic [CW-1:0]    r_count;

  logic             w_accept;
  logic             w_lastIter;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_trial;
  logic             w_borrow;
  logic [WIDTH:0]   w_remNext;
  logic [WIDTH-1:0] w_quoNext;
  logic             w_unusedRemTop;

  assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_lastIter = (r_count == CW'(1));

  // The shifted partial remainder needs WIDTH+1 bits so its old MSB survives.
  assign w_shifted = {r_rem, r_quo[WIDTH-1]};

  eight_bit_subtractor #(
    .W(WIDTH + 1)
  ) u_trialSub (
    .i_a     (w_shifted),
    .i_b     ({1'b0, r_divisor}),
    .o_diff  (w_trial),
    .o_borrow(w_borrow)
  );

  assign w_remNext      = w_borrow ? w_shifted : w_trial;
  assign w_quoNext      = {r_quo[WIDTH-2:0], ~w_borrow};
  assign w_unusedRemTop = w_remNext[WIDTH];

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_nextState = (D == '0) ? DONE : RUN;
        end else begin
          w_nextState = IDLE;
        end
      end
      RUN: begin
        if (w_lastIter) begin
          w_nextState = DONE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Results are only written on the accept edge (divide by zero) or the last iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem       <= '0;
      r_quo       <= '0;
      r_divisor   <= '0;
      r_count     <= '0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_divisor <= D;
      if (D == '0) begin
        Q           <= '1;
        R           <= N;
        div_by_zero <= 1'b1;
      end else begin
        r_rem   <= '0;
        r_quo   <= N;
        r_count <= CW'(WIDTH);
      end
    end else if (r_state == RUN) begin
      r_rem   <= w_remNext[WIDTH-1:0];
      r_quo   <= w_quoNext;
      r_count <= r_count - CW'(1);
      if (w_lastIter) begin
        Q           <= w_quoNext;
        R           <= w_remNext[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
